// File: rtl/image_fetch.sv
// image_fetch: walks the image ROM in its down-counting address order (N..1) and
// re-emits the captured frame as a raster-ordered valid/ready pixel stream.
module image_fetch #(
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  localparam int unsigned RowW  = (IMG_H > 1) ? $clog2(IMG_H) : 1,
  localparam int unsigned ColW  = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     go,
  output logic [ADDR_W-1:0]        address,
  output logic                     start,
  input  logic signed [DATA_W-1:0] input_feature,
  input  logic                     ready_in,
  output logic signed [DATA_W-1:0] pix_data,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic [RowW-1:0]          row,
  output logic [ColW-1:0]          col,
  output logic                     last,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned NPix = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] NAddr  = ADDR_W'(NPix);
  localparam logic [ADDR_W-1:0] LastK  = ADDR_W'(NPix - 1);
  localparam logic [ColW-1:0]   ColMax = ColW'(IMG_W - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   remaining_q, remaining_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic                done_q, done_d;

  // Three-entry skid FIFO: covers the pixel in the ROM pipe plus the one being addressed.
  logic signed [DATA_W-1:0] fifo_q [3];
  logic [1:0]          wr_ptr_q, wr_ptr_d;
  logic [1:0]          rd_ptr_q, rd_ptr_d;
  logic [1:0]          count_q, count_d;
  logic [2:0]          count_next;

  logic [ADDR_W-1:0]   out_k_q, out_k_d;
  logic [RowW-1:0]     row_q, row_d;
  logic [ColW-1:0]     col_q, col_d;

  logic                capture;
  logic                pop;
  logic                issue;
  logic                frame_end;

  assign busy      = (state_q != StIdle);
  assign start     = busy;
  assign pix_valid = (count_q != 2'd0);
  assign capture   = ready_in & start;
  assign pop       = pix_valid & pix_ready;
  assign last      = pix_valid & (out_k_q == LastK);
  assign frame_end = pop & last & (state_q == StDrain);

  assign count_next = {1'b0, count_q} + {2'b00, capture} - {2'b00, pop};
  // Room check counts the address on the bus now, whose data lands next cycle.
  assign issue = (remaining_q != '0) &&
                 ((count_next + {2'b00, (address_q != '0)}) <= 3'd2);

  // Head is forced to 0 when empty so the stream is quiet while idle.
  assign pix_data = pix_valid ? fifo_q[rd_ptr_q] : '0;
  assign address  = address_q;
  assign row      = row_q;
  assign col      = col_q;
  assign done     = done_q;

  // Sequencer next state: issue addresses while there is room, then wait for the last pop.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    address_d   = '0;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          address_d   = NAddr;
          remaining_d = NAddr - 1'b1;
          state_d     = (NPix == 1) ? StDrain : StFetch;
        end
      end
      StFetch: begin
        if (issue) begin
          address_d   = remaining_q;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == {{(ADDR_W-1){1'b0}}, 1'b1}) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (frame_end) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO pointers and raster position of the head pixel.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_next[1:0];
    out_k_d  = out_k_q;
    row_d    = row_q;
    col_d    = col_q;
    if (capture) begin
      wr_ptr_d = (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
      out_k_d  = out_k_q + 1'b1;
      if (col_q == ColMax) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    if (frame_end) begin
      wr_ptr_d = 2'd0;
      rd_ptr_d = 2'd0;
      count_d  = 2'd0;
      out_k_d  = '0;
      row_d    = '0;
      col_d    = '0;
    end
  end

  // Control and counter state; asynchronous reset drops everything back to idle.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      address_q   <= '0;
      done_q      <= 1'b0;
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      count_q     <= 2'd0;
      out_k_q     <= '0;
      row_q       <= '0;
      col_q       <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      address_q   <= address_d;
      done_q      <= done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_k_q     <= out_k_d;
      row_q       <= row_d;
      col_q       <= col_d;
    end
  end

  // FIFO storage; contents are don't-care while count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      fifo_q[wr_ptr_q] <= input_feature;
    end
  end

  // The issue rule must keep every capture within the three entries.
  no_overflow: assert property (@(posedge clk) disable iff (!n_reset)
                                !(capture && (count_q == 2'd3)));

endmodule

// File: tb/tb_image_fetch.sv
// Directed bench for image_fetch: 28x28 frames under several backpressure patterns,
// mid-frame reset, and a 1x1 instance for the single-pixel corner.
module tb_image_fetch;

  localparam int N = 784;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic n_reset;

  // 28x28 instance
  logic               go, pix_ready, start, ready_in, pix_valid, last, busy, done;
  logic [15:0]        address;
  logic signed [15:0] input_feature, pix_data;
  logic [4:0]         row, col;

  // 1x1 instance
  logic               go1, pix_ready1, start1, ready_in1, pix_valid1, last1, busy1, done1;
  logic [15:0]        address1;
  logic signed [15:0] input_feature1, pix_data1;
  logic               row1, col1;

  int checks = 0;
  int errors = 0;

  image_fetch dut (
    .clk(clk), .n_reset(n_reset), .go(go), .address(address), .start(start),
    .input_feature(input_feature), .ready_in(ready_in), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .row(row), .col(col), .last(last),
    .busy(busy), .done(done)
  );

  image_fetch #(.IMG_W(1), .IMG_H(1), .DATA_W(16), .ADDR_W(16)) dut1 (
    .clk(clk), .n_reset(n_reset), .go(go1), .address(address1), .start(start1),
    .input_feature(input_feature1), .ready_in(ready_in1), .pix_data(pix_data1),
    .pix_valid(pix_valid1), .pix_ready(pix_ready1), .row(row1), .col(col1), .last(last1),
    .busy(busy1), .done(done1)
  );

  // ROM model: mem[k] = k - 392 with k = N - address; 0x7EAD is the address-0 pad.
  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ready_in      <= 1'b0;
      input_feature <= '0;
    end else begin
      ready_in      <= start && (address != 16'd0);
      input_feature <= (address != 16'd0) ? 16'(N - int'(address) - 392) : 16'sh7EAD;
    end
  end

  // 1x1 ROM model: mem[0] = -5.
  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ready_in1      <= 1'b0;
      input_feature1 <= '0;
    end else begin
      ready_in1      <= start1 && (address1 != 16'd0);
      input_feature1 <= (address1 != 16'd0) ? -16'sd5 : 16'sh7EAD;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame on the 28x28 instance; go at cycle 0. mode 0: ready=1,
  // 1: random ready, 2: ready=0 for cycles 0..11. Per-beat ordering checked inline.
  task automatic run_frame(input int mode, input int go_a, input int go_b, input int max_cyc,
                           output int beats, output int dones, output int done_cyc,
                           output int first_valid, output int issued, output int last_addr_cyc);
    int exp_addr;
    int k;
    logic signed [15:0] exp_data;
    beats = 0; dones = 0; done_cyc = -1; first_valid = -1; issued = 0; last_addr_cyc = -1;
    exp_addr = N;
    pix_ready = (mode == 0);
    step();
    go = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      step();
      go = (c == go_a) || (c == go_b);
      if (address != 16'd0) begin
        checks++;
        if (address !== 16'(exp_addr)) begin
          errors++;
          $display("FAIL addr_seq cycle %0d: got %0d want %0d", c, address, exp_addr);
        end
        exp_addr--;
        issued++;
        last_addr_cyc = c;
      end
      checks++;
      if (issued - beats > 3) begin
        errors++;
        $display("FAIL outstanding cycle %0d: got %0d want <=3", c, issued - beats);
      end
      if (mode == 2 && c < 12) begin
        checks++;
        if (address !== ((c <= 3) ? 16'(N - c + 1) : 16'd0)) begin
          errors++;
          $display("FAIL stall_addr cycle %0d: got %0d", c, address);
        end
        if (c >= 3) begin
          checks++;
          if (pix_valid !== 1'b1 || pix_data !== -16'sd392 || row !== 5'd0 || col !== 5'd0)
          begin
            errors++;
            $display("FAIL stall_hold cycle %0d: valid %b data %0d want 1 -392",
                     c, pix_valid, pix_data);
          end
        end
      end
      if (pix_valid === 1'b1 && first_valid < 0) first_valid = c;
      case (mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = 1'($urandom_range(0, 1));
        default: pix_ready = (c >= 12);
      endcase
      if (pix_valid === 1'b1 && pix_ready) begin
        k = beats;
        exp_data = 16'(k - 392);
        checks++;
        if (pix_data !== exp_data || row !== 5'(k / 28) || col !== 5'(k % 28) ||
            last !== (k == N - 1)) begin
          errors++;
          $display("FAIL beat %0d cycle %0d: got d=%0d r=%0d c=%0d l=%b want d=%0d r=%0d c=%0d",
                   k, c, pix_data, row, col, last, exp_data, k / 28, k % 28);
        end
        beats++;
      end
      if (done === 1'b1) begin
        dones++;
        done_cyc = c;
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_at_done cycle %0d: got %b want 0", c, busy);
        end
      end else if (dones == 0) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_in_frame cycle %0d: got %b want 1", c, busy);
        end
      end
      if (dones > 0 && c >= done_cyc + 3) break;
    end
    go = 1'b0;
    pix_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_reset = 1'b0; go = 1'b0; go1 = 1'b0; pix_ready = 1'b0; pix_ready1 = 1'b1;
    step();
    step();
    checks++;
    if (address !== 16'd0 || start !== 1'b0 || pix_valid !== 1'b0 || pix_data !== 16'sd0 ||
        row !== 5'd0 || col !== 5'd0 || last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: addr %0d start %b valid %b busy %b done %b want all 0",
               address, start, pix_valid, busy, done);
    end
    checks++;
    if (address1 !== 16'd0 || start1 !== 1'b0 || pix_valid1 !== 1'b0 || last1 !== 1'b0 ||
        busy1 !== 1'b0 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs_1x1: valid %b last %b want 0 0", pix_valid1, last1);
    end
    n_reset = 1'b1;
    step();
  endtask

  task automatic test_free_flow();
    int beats, dones, dc, fv, iss, lac;
    run_frame(0, -1, -1, N + 20, beats, dones, dc, fv, iss, lac);
    checks++;
    if (beats != N) begin errors++; $display("FAIL ff_beats: got %0d want %0d", beats, N); end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL ff_dones: got %0d want 1", dones); end
    checks++;
    if (dc != N + 3) begin errors++; $display("FAIL ff_done_cyc: got %0d want %0d", dc, N + 3); end
    checks++;
    if (fv != 3) begin errors++; $display("FAIL ff_first_valid: got %0d want 3", fv); end
    checks++;
    if (iss != N || lac != N) begin
      errors++;
      $display("FAIL ff_addr_span: got %0d issues ending cycle %0d want %0d %0d", iss, lac, N, N);
    end
  endtask

  task automatic test_stall_start();
    int beats, dones, dc, fv, iss, lac;
    run_frame(2, -1, -1, N + 100, beats, dones, dc, fv, iss, lac);
    checks++;
    if (beats != N || dones != 1) begin
      errors++;
      $display("FAIL stall_frame: got %0d beats %0d dones want %0d 1", beats, dones, N);
    end
  endtask

  task automatic test_random_backpressure();
    int beats, dones, dc, fv, iss, lac;
    run_frame(1, -1, -1, 4000, beats, dones, dc, fv, iss, lac);
    checks++;
    if (beats != N || dones != 1 || iss != N) begin
      errors++;
      $display("FAIL random_frame: got %0d beats %0d dones %0d issues want %0d 1 %0d",
               beats, dones, iss, N, N);
    end
  endtask

  task automatic test_go_while_busy();
    int beats, dones, dc, fv, iss, lac;
    run_frame(0, 5, 400, N + 20, beats, dones, dc, fv, iss, lac);
    checks++;
    if (beats != N || dones != 1 || dc != N + 3) begin
      errors++;
      $display("FAIL go_busy: got %0d beats %0d dones done@%0d want %0d 1 %0d",
               beats, dones, dc, N, N + 3);
    end
    run_frame(0, -1, -1, N + 20, beats, dones, dc, fv, iss, lac);
    checks++;
    if (beats != N || dones != 1 || fv != 3) begin
      errors++;
      $display("FAIL second_frame: got %0d beats %0d dones first@%0d want %0d 1 3",
               beats, dones, fv, N);
    end
  endtask

  task automatic test_reset_mid_frame();
    int beats, dones, dc, fv, iss, lac;
    int early_dones = 0;
    pix_ready = 1'b1;
    step();
    go = 1'b1;
    for (int c = 1; c <= 299; c++) begin
      step();
      go = 1'b0;
      if (done === 1'b1) early_dones++;
    end
    // Cycle 299: head pixel is k = 296 -> row 10, col 16.
    checks++;
    if (busy !== 1'b1 || pix_valid !== 1'b1 || row !== 5'd10 || col !== 5'd16) begin
      errors++;
      $display("FAIL pre_reset: busy %b valid %b row %0d col %0d want 1 1 10 16",
               busy, pix_valid, row, col);
    end
    step();
    n_reset = 1'b0;
    #1;
    checks++;
    if (address !== 16'd0 || start !== 1'b0 || pix_valid !== 1'b0 || pix_data !== 16'sd0 ||
        row !== 5'd0 || col !== 5'd0 || last !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: addr %0d valid %b row %0d col %0d busy %b want 0",
               address, pix_valid, row, col, busy);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (done === 1'b1) early_dones++;
    end
    n_reset = 1'b1;
    step();
    if (done === 1'b1) early_dones++;
    checks++;
    if (early_dones != 0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d done pulses want 0", early_dones);
    end
    run_frame(0, -1, -1, N + 20, beats, dones, dc, fv, iss, lac);
    checks++;
    if (beats != N || dones != 1 || dc != N + 3) begin
      errors++;
      $display("FAIL restart_frame: got %0d beats %0d dones done@%0d want %0d 1 %0d",
               beats, dones, dc, N, N + 3);
    end
  endtask

  task automatic test_single_pixel();
    pix_ready1 = 1'b1;
    step();
    go1 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      go1 = 1'b0;
      checks++;
      if (address1 !== ((c == 1) ? 16'd1 : 16'd0)) begin
        errors++;
        $display("FAIL px1_addr cycle %0d: got %0d", c, address1);
      end
      checks++;
      if (pix_valid1 !== (c == 3) || done1 !== (c == 4) || busy1 !== (c >= 1 && c <= 3) ||
          start1 !== busy1) begin
        errors++;
        $display("FAIL px1_ctrl cycle %0d: valid %b done %b busy %b", c, pix_valid1, done1, busy1);
      end
      if (c == 3) begin
        checks++;
        if (pix_data1 !== -16'sd5 || last1 !== 1'b1 || row1 !== 1'b0 || col1 !== 1'b0) begin
          errors++;
          $display("FAIL px1_beat: got d=%0d last %b want -5 1", pix_data1, last1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_flow();
    test_stall_start();
    test_random_backpressure();
    test_go_while_busy();
    test_reset_mid_frame();
    test_single_pixel();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_fetch.md
# image_fetch

Read-side sequencer for the image ROM. On a `go` pulse it walks the ROM address port in the ROM's down-counting convention (N..1; 0 means idle) and captures each returned feature. It then presents the frame to the first CNN layer as a raster-ordered valid/ready pixel stream tagged with row, column and last-pixel flags. A 3-entry skid FIFO absorbs the ROM's one-cycle read latency, so downstream backpressure never drops or duplicates a pixel.

## Interface
- IMG_W, 28: image width in pixels.
- IMG_H, 28: image height in pixels; N = IMG_W*IMG_H = 784.
- DATA_W, 16: feature width, signed.
- ADDR_W, 16: ROM address width.
- clk  in  1  clock.
- n_reset  in  1  reset, asynchronous, active-low.
- go  in  1  start pulse; sampled in IDLE only.
- address  out  ADDR_W  ROM address. Registered. 0 when not issuing.
- start  out  1  ROM output enable. High in FETCH and DRAIN.
- input_feature  in  DATA_W  ROM data. Signed. Valid the cycle after a nonzero address.
- ready_in  in  1  ROM data-valid. 1 the cycle after a nonzero address.
- pix_data  out  DATA_W  FIFO head pixel, signed.
- pix_valid  out  1  pix_data valid; equals FIFO count != 0.
- pix_ready  in  1  downstream accept.
- row  out  clog2(IMG_H)  row of the head pixel.
- col  out  clog2(IMG_W)  column of the head pixel.
- last  out  1  head pixel is index N-1.
- busy  out  1  high in FETCH or DRAIN.
- done  out  1  one-cycle pulse at frame completion.

## Operation
- Reset values: every output is 0, state IDLE, FIFO empty, all counters 0.
- Pixel index k = N - address. The ROM returns pixel k one cycle after `address` is presented.
- FSM, IDLE:
  - address = 0.
  - On go: load remaining = N, issue address N, go to FETCH.
- FSM, FETCH:
  - Issue rule: each cycle, address <= (issue ? remaining : 0) and remaining decrements on issue.
  - After the issue of address 1, go to DRAIN.
- FSM, DRAIN:
  - address = 0.
  - When the last-pixel handshake occurs (pix_valid & pix_ready & last): pulse done, go to IDLE.
- Issue condition: issue = (remaining != 0) & (count_next + (address != 0) <= 2).
  - count_next = count + capture - pop.
  - capture = ready_in & start.
  - pop = pix_valid & pix_ready.
  - This guarantees the FIFO never overflows. A capture into a full FIFO is an assertion failure.
- The issue pattern holds address at 0 between issues, so ready_in alone qualifies capture. A held address never re-captures.
- Pop side:
  - Maintain an output index out_k, with row/col counters, that advance on pop.
  - col wraps IMG_W-1 -> 0, with a row increment at the wrap.
  - last = (out_k == N-1).
  - All indices clear on return to IDLE.
- Data passes through unmodified: no sign extension, no arithmetic.
- go while busy is ignored. The ROM address-0 pad value is never captured.
- Reset mid-frame: asynchronous clear to IDLE. The FIFO is flushed, address returns to 0, and no done pulse is generated.

## Timing
- go sampled high at the end of cycle 0:
  - address = N in cycle 1.
  - ROM data in cycle 2.
  - pix_valid in cycle 3.
- Latency is 2 cycles from a nonzero address to pix_valid, and 3 cycles from go to the first pix_valid.
- Sustained throughput is 1 pixel/cycle while pix_ready = 1.
- With continuous pix_ready:
  - addresses N..1 appear in cycles 1..N;
  - beats appear in cycles 3..N+2;
  - done pulses in cycle N+3, which is also the first cycle with busy = 0.
- With pix_ready = 0, at most 3 addresses are outstanding or buffered before issuing stalls.
- pix_data, row, col and last are stable while pix_valid & !pix_ready.

## Test plan
- Free-flow frame: ROM model with mem[k] = k - 392, pix_ready = 1, go at cycle 0.
  - Addresses 784,783,...,1 in cycles 1..784.
  - Beat k carries pix_data = k - 392, row = k/28, col = k%28.
  - last only on k = 783; done in cycle 787; exactly 784 beats.
- Stall at start: pix_ready = 0 from cycle 0.
  - Addresses 784, 783, 782 in cycles 1-3, then 0 from cycle 4.
  - pix_valid = 1 with pix_data = mem[0] held stable.
  - Releasing pix_ready resumes with no loss or duplication.
- Random backpressure (50% pix_ready) over a full frame:
  - All 784 pixels arrive in order with correct row/col.
  - FIFO never overflows.
  - address is nonzero only on issue cycles.
- go repeated while busy (cycles 5 and 400): no restart, single done, 784 beats; a second go after done runs a clean second frame.
- Reset asserted at cycle 300 mid-frame: all outputs 0 immediately and no done pulse; a subsequent go restarts from address 784 and pixel 0.
- Single-pixel geometry, IMG_W = IMG_H = 1: address 1 in cycle 1, one beat with last = 1 in cycle 3, done in cycle 4.
